// File: rtl/sensor_ctrl_pkg.sv
// Shared types and default geometry for the sensor controller slice.
package sctrl_pkg;

  localparam int unsigned SCTRL_DEPTH = 64;
  localparam int unsigned SCTRL_AW    = 6;
  localparam int unsigned SCTRL_DW    = 32;

  typedef enum logic [1:0] {IDLE, FILL, FULL} sctrl_state_t;

endpackage

// File: rtl/sensor_ctrl_if.sv
// CPU-side and sensor-side signals of sensor_ctrl grouped into one bundle.
// Optional SCTRL_OVERRUN_CNT_EN adds the sctrl_ovr_cnt overrun counter output.
interface sensor_ctrl_if #(
  parameter int unsigned AW = sctrl_pkg::SCTRL_AW,
  parameter int unsigned DW = sctrl_pkg::SCTRL_DW
);

  logic          sctrl_en;
  logic          sctrl_clear;
  logic [AW-1:0] sctrl_addr;
  logic          sensor_ready;
  logic [DW-1:0] sensor_out;
  logic          sensor_en;
  logic          sctrl_interrupt;
  logic [DW-1:0] sctrl_out;
`ifdef SCTRL_OVERRUN_CNT_EN
  logic [15:0]   sctrl_ovr_cnt;

  modport master (
    output sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
    input  sensor_en, sctrl_interrupt, sctrl_out, sctrl_ovr_cnt
  );

  modport slave (
    input  sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
    output sensor_en, sctrl_interrupt, sctrl_out, sctrl_ovr_cnt
  );
`else
  modport master (
    output sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
    input  sensor_en, sctrl_interrupt, sctrl_out
  );

  modport slave (
    input  sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
    output sensor_en, sctrl_interrupt, sctrl_out
  );
`endif

endinterface

// File: rtl/sensor_ctrl_buf.sv
// 1W1R register file with registered read; kept apart from the FSM so it can
// be replaced by an SRAM macro. Only the read register is reset.
module sctrl_buf #(
  parameter int unsigned DEPTH = sctrl_pkg::SCTRL_DEPTH,
  parameter int unsigned AW    = sctrl_pkg::SCTRL_AW,
  parameter int unsigned DW    = sctrl_pkg::SCTRL_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read samples the array before this cycle's write lands: old data on collision.
  always_comb begin
    rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sensor_ctrl.sv
// Core-side sensor controller: captures one word per sensor_ready into a frame
// buffer and interrupts when full. Optional macro: SCTRL_OVERRUN_CNT_EN.
module sensor_ctrl
  import sctrl_pkg::*;
#(
  parameter int unsigned DEPTH = SCTRL_DEPTH,
  parameter int unsigned AW    = SCTRL_AW,
  parameter int unsigned DW    = SCTRL_DW
) (
  input  logic          clk,
  input  logic          rstn,
  sensor_ctrl_if.slave  bus
);

  sctrl_state_t  state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          irq_q, irq_d;
  logic          sen;
  logic          wr_en;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    irq_d   = irq_q;
    sen     = (state_q == FILL) && bus.sctrl_en && !bus.sctrl_clear;
    wr_en   = sen && bus.sensor_ready;
    if (bus.sctrl_clear) begin
      state_d = IDLE;
      wptr_d  = '0;
      irq_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.sctrl_en) state_d = FILL;
        FILL: begin
          if (!bus.sctrl_en) begin
            state_d = IDLE;
          end else if (bus.sensor_ready) begin
            wptr_d = wptr_q + 1'b1;
            // DEPTH is a power of two, so the last slot is all-ones and wptr wraps to 0.
            if (wptr_q == '1) begin
              state_d = FULL;
              irq_d   = 1'b1;
            end
          end
        end
        FULL:    state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.sensor_en       = sen;
  assign bus.sctrl_interrupt = irq_q;

  sctrl_buf #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_buf (
    .clk   (clk),
    .rst_n (rstn),
    .we    (wr_en),
    .waddr (wptr_q),
    .wdata (bus.sensor_out),
    .raddr (bus.sctrl_addr),
    .rdata (bus.sctrl_out)
  );

`ifdef SCTRL_OVERRUN_CNT_EN
  logic [15:0] ovr_q, ovr_d;

  // Clear zeroes the count first; a sample dropped by that same clear is then counted.
  always_comb begin
    ovr_d = bus.sctrl_clear ? 16'd0 : ovr_q;
    if (bus.sensor_ready && (bus.sctrl_clear || state_q == FULL) && ovr_d != 16'hFFFF)
      ovr_d = ovr_d + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ovr_q <= '0;
    else       ovr_q <= ovr_d;
  end

  assign bus.sctrl_ovr_cnt = ovr_q;
`endif

endmodule

// File: tb/tb_sensor_ctrl.sv
// Self-checking bench for sensor_ctrl: a directed vector table, directed frame
// sequences and randomized traffic against a frame-count reference model.
module tb_sensor_ctrl;
  import sctrl_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sensor_ctrl_if #(.AW(SCTRL_AW), .DW(SCTRL_DW)) bus ();

  sensor_ctrl #(
    .DEPTH (SCTRL_DEPTH),
    .AW    (SCTRL_AW),
    .DW    (SCTRL_DW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: words captured in the current frame, last-known buffer
  // contents, and whether the controller is armed (enabled last cycle, no clear).
  logic [31:0] m_mem [64];
  bit          m_val [64];
  int          m_cnt = 0;
  bit          m_acq = 1'b0;
  int          m_ovr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit en, input bit clr, input bit rdy,
                       input logic [31:0] d, input logic [5:0] a);
    bus.sctrl_en     = en;
    bus.sctrl_clear  = clr;
    bus.sensor_ready = rdy;
    bus.sensor_out   = d;
    bus.sctrl_addr   = a;
  endtask

  // One clock of stimulus, checked against the model. Entered at posedge+1.
  task automatic step(input bit en, input bit clr, input bit rdy,
                      input logic [31:0] d, input logic [5:0] a);
    bit          sen;
    bit          was_full;
    logic [31:0] old;
    bit          oldv;
    drive(en, clr, rdy, d, a);
    #1;
    sen = m_acq && en && !clr;
    chk("sensor_en", bus.sensor_en, sen);
    old      = m_mem[a];
    oldv     = m_val[a];
    was_full = (m_cnt == 64);
    @(posedge clk);
    #1;
    if (clr) m_cnt = 0;
    else if (sen && rdy) begin
      m_mem[m_cnt % 64] = d;
      m_val[m_cnt % 64] = 1'b1;
      m_cnt++;
    end
    if (clr) m_ovr = 0;
    if (rdy && (clr || was_full) && m_ovr < 65535) m_ovr++;
    m_acq = (m_cnt < 64) && en && !clr;
    chk("interrupt", bus.sctrl_interrupt, m_cnt == 64);
    if (oldv) chk("rdata", bus.sctrl_out, old);
`ifdef SCTRL_OVERRUN_CNT_EN
    chk("ovr_cnt", bus.sctrl_ovr_cnt, m_ovr);
`endif
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sensor_en", bus.sensor_en, 1'b0);
    chk("rst_interrupt", bus.sctrl_interrupt, 1'b0);
    chk("rst_sctrl_out", bus.sctrl_out, 32'h0);
`ifdef SCTRL_OVERRUN_CNT_EN
    chk("rst_ovr_cnt", bus.sctrl_ovr_cnt, 16'h0);
`endif
    rstn  = 1'b1;
    m_cnt = 0;
    m_acq = 1'b0;
    m_ovr = 0;
  endtask

  typedef struct {
    bit          en, clr, rdy;
    logic [31:0] d;
    logic [5:0]  a;
    bit          sen, irq, chk_out;
    logic [31:0] out;
  } vec_t;

  vec_t tbl [10];

  initial begin
    for (int i = 0; i < 64; i++) begin
      m_mem[i] = '0;
      m_val[i] = 1'b0;
    end
    // en clr rdy data a | sen irq chk_out out (out = sctrl_out after the edge)
    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h0000_0011, 6'd0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 6'd0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 32'hAAAA_0001, 6'd0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'hCCCC_0003, 6'd0, 1'b0, 1'b0, 1'b1, 32'hAAAA_0001};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'hDDDD_0004, 6'd0, 1'b0, 1'b0, 1'b1, 32'hAAAA_0001};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 32'hBBBB_0005, 6'd0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 32'hEEEE_0006, 6'd0, 1'b0, 1'b0, 1'b1, 32'hBBBB_0005};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 6'd0, 1'b0, 1'b0, 1'b1, 32'hBBBB_0005};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_0008, 6'd1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 6'd1, 1'b1, 1'b0, 1'b1, 32'hFFFF_0008};

    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].rdy, tbl[i].d, tbl[i].a);
      #1;
      chk($sformatf("vec%0d_sensor_en", i), bus.sensor_en, tbl[i].sen);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_interrupt", i), bus.sctrl_interrupt, tbl[i].irq);
      if (tbl[i].chk_out) chk($sformatf("vec%0d_sctrl_out", i), bus.sctrl_out, tbl[i].out);
    end
    m_mem[0] = 32'hBBBB_0005; m_val[0] = 1'b1;
    m_mem[1] = 32'hFFFF_0008; m_val[1] = 1'b1;

    // Full frame with widely spaced pulses, then readback.
    do_reset();
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b0, 1'b1, 32'h1000_0000 + i, '0);
      if (i == 62) chk("irq_before_last", bus.sctrl_interrupt, 1'b0);
      if (i == 63) chk("irq_after_last", bus.sctrl_interrupt, 1'b1);
      if (i < 63) repeat (1023) step(1'b1, 1'b0, 1'b0, '0, '0);
    end
    for (int i = 0; i < 65; i++) step(1'b1, 1'b0, 1'b0, '0, 6'(i % 64));
    step(1'b1, 1'b0, 1'b0, '0, 6'd63);
    chk("readback_63", bus.sctrl_out, 32'h1000_003F);

    // Pulses while FULL must be ignored.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, '0);
      step(1'b0, 1'b0, 1'b0, '0, '0);
    end
    for (int i = 0; i < 65; i++) step(1'b0, 1'b0, 1'b0, '0, 6'(i % 64));
    chk("full_hold_irq", bus.sctrl_interrupt, 1'b1);
`ifdef SCTRL_OVERRUN_CNT_EN
    chk("full_hold_ovr", bus.sctrl_ovr_cnt, 16'd5);
`endif

    // Clear colliding with a sample, then a fresh frame.
    step(1'b1, 1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 32'h2100_0000 + i, '0);
    step(1'b1, 1'b1, 1'b1, 32'h0C01_11DE, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b0, 1'b1, 32'h2000_0000 + i, '0);
      if (i == 62) chk("coll_irq_62", bus.sctrl_interrupt, 1'b0);
      if (i == 63) chk("coll_irq_63", bus.sctrl_interrupt, 1'b1);
    end
    step(1'b1, 1'b0, 1'b0, '0, 6'd0);
    chk("coll_addr0", bus.sctrl_out, 32'h2000_0000);

    // Enable pause keeps the write pointer.
    step(1'b1, 1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 32'h3000_0000 + i, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'hBAD0_0000 + i, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b1, 32'h4444_0014, '0);
    step(1'b1, 1'b0, 1'b0, '0, 6'd20);
    chk("pause_addr20", bus.sctrl_out, 32'h4444_0014);

    // Asynchronous reset between edges, mid-fill.
    step(1'b1, 1'b0, 1'b0, '0, 6'd20);
    step(1'b1, 1'b0, 1'b1, 32'h4444_0015, 6'd20);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_sensor_en", bus.sensor_en, 1'b0);
    chk("async_interrupt", bus.sctrl_interrupt, 1'b0);
    chk("async_sctrl_out", bus.sctrl_out, 32'h0);
    m_cnt = 0;
    m_acq = 1'b0;
    m_ovr = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 32'h5000_0000 + i, '0);
    step(1'b1, 1'b0, 1'b0, '0, 6'd0);
    chk("restart_addr0", bus.sctrl_out, 32'h5000_0000);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 8) != 0, ($urandom % 64) == 0, ($urandom % 3) == 0,
           $urandom, 6'($urandom % 64));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
